// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 definitions: transmitter FSM states, error codes, frame sizing, odd parity.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_REQ        = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_ACK        = 3'd4,
    ST_LINES_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_ACK  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Bits the host shifts out after the start bit: 8 data + parity + stop.
  localparam int FRAME_BITS = 10;

  // Odd parity: returns 1 when data holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
// One PS/2 line: 2-FF synchroniser, FILTER_LEN-sample glitch filter, registered falling-edge strobe.
// Latency: 2 sync + FILTER_LEN filter cycles from pin change to o_level; o_fall asserts with the new level.
// Backpressure: none; free-running, strobe is a single-cycle pulse.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   i_line       raw asynchronous pin level
//   o_level      filtered level (idles high)
//   o_fall       one-cycle strobe when o_level goes 1 -> 0
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], i_line};
    level_d = level_q;
    cnt_d   = '0;
    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = level_q & ~level_d;
  end

  // Sync and level flops reset high so an idle bus produces no edge at reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data + odd parity + stop, check ACK.
// Latency: o_busy one cycle after i_start; frame time is set by the device clock (~11 device periods).
// Backpressure: i_start is ignored while o_busy=1 (no queueing); o_done/o_error end each request.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   i_start, i_data[7:0]       send request (one cycle) and byte, latched when idle
//   PS2C, PS2D                 raw pin levels
//   o_ps2c_low, o_ps2d_low     open-drain pull-down enables (0 = released)
//   o_busy, o_rx_inhibit       transfer in progress; receiver ignores the bus meanwhile
//   o_done, o_error            single-cycle completion / abort pulses
//   o_err_code[1:0]            01 no ACK, 10 timeout; holds the last code
// Build option: define PS2_TX_RETRY_EN to retry a failed byte up to RETRY_MAX times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8,
  parameter int RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       o_ps2c_low,
  output logic       o_ps2d_low,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [1:0] o_err_code,
  output logic       o_rx_inhibit
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic c_level, c_fall, d_level;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_clk (
    .clk     (clk),
    .reset   (reset),
    .i_line  (PS2C),
    .o_level (c_level),
    .o_fall  (c_fall)
  );

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_dat (
    .clk     (clk),
    .reset   (reset),
    .i_line  (PS2D),
    .o_level (d_level),
    .o_fall  ()
  );

  ps2_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;     // {stop, parity, data[7:0]}, sent LSB first
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  ps2c_low_q, ps2c_low_d;
  logic                  ps2d_low_q, ps2d_low_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;

  logic                  to_active;
  logic                  err_hit;
  logic [1:0]            err_kind;
  logic                  retry_ok;

`ifdef PS2_TX_RETRY_EN
  localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX);
  logic [7:0]            retry_q, retry_d;
`endif

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    ps2c_low_d = ps2c_low_q;
    ps2d_low_d = ps2d_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    err_hit    = 1'b0;
    err_kind   = ERR_NONE;
    retry_ok   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
    retry_ok   = (retry_q < RETRY_LIMIT);
`else
    // Retries are compiled out; the comparison is never true for a legal
    // RETRY_MAX and keeps the parameter referenced in this build.
    retry_ok   = (RETRY_MAX < 0);
`endif

    // Device-clock watchdog. A fall in the same cycle as expiry wins.
    to_active = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                (state_q == ST_ACK) || (state_q == ST_LINES_IDLE);
    if (to_active) begin
      if (c_fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LIMIT) begin
        err_hit  = 1'b1;
        err_kind = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          frame_d    = {1'b1, odd_parity(i_data), i_data};
          bit_cnt_d  = '0;
          inh_cnt_d  = '0;
          to_cnt_d   = '0;
          busy_d     = 1'b1;
          ps2c_low_d = 1'b1;
          ps2d_low_d = 1'b0;
          state_d    = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d    = '0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          // Start bit goes low in the same cycle the clock is released.
          ps2c_low_d = 1'b0;
          ps2d_low_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      ST_REQ: begin
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (c_fall) begin
          ps2d_low_d = ~frame_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (c_fall) begin
          if (d_level) begin
            err_hit  = 1'b1;
            err_kind = ERR_NO_ACK;
          end else begin
            state_d = ST_LINES_IDLE;
          end
        end
      end

      ST_LINES_IDLE: begin
        if (c_level && d_level) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_hit = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: release both lines; either restart the byte or report failure.
    if (err_hit) begin
      ps2c_low_d = 1'b0;
      ps2d_low_d = 1'b0;
      if (retry_ok) begin
        ps2c_low_d = 1'b1;
        inh_cnt_d  = '0;
        bit_cnt_d  = '0;
        state_d    = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q + 1'b1;
`endif
      end else begin
        busy_d     = 1'b0;
        error_d    = 1'b1;
        err_code_d = err_kind;
        state_d    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      ps2c_low_q <= 1'b0;
      ps2d_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      ps2c_low_q <= ps2c_low_d;
      ps2d_low_q <= ps2d_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign o_ps2c_low   = ps2c_low_q;
  assign o_ps2d_low   = ps2d_low_q;
  assign o_busy       = busy_q;
  assign o_rx_inhibit = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx with a PS/2 device model on open-drain pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 600;
  localparam int FL   = 4;
  localparam int RM   = 2;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int MAX_ATT = RM + 1;
`else
  localparam int MAX_ATT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [7:0] i_data;
  logic       dev_clk_low, dev_data_low;
  wire        ps2c, ps2d;
  logic       o_ps2c_low, o_ps2d_low, o_busy, o_done, o_error, o_rx_inhibit;
  logic [1:0] o_err_code;

  // Open-drain bus: either side may pull low, pull-ups otherwise.
  assign ps2c = ~(o_ps2c_low | dev_clk_low);
  assign ps2d = ~(o_ps2d_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL),
    .RETRY_MAX      (RM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_data       (i_data),
    .PS2C         (ps2c),
    .PS2D         (ps2d),
    .o_ps2c_low   (o_ps2c_low),
    .o_ps2d_low   (o_ps2d_low),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_err_code   (o_err_code),
    .o_rx_inhibit (o_rx_inhibit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inh_starts = 0;
  int inh_run = 0;
  int last_inh_len = 0;
  int inhibit_mism = 0;
  logic [1:0] exp_code;

  // Bus monitor: pulse counts, host clock-inhibit run lengths, rx_inhibit tracking.
  always @(negedge clk) begin
    if (o_done === 1'b1) done_cnt++;
    if (o_error === 1'b1) err_cnt++;
    if (o_rx_inhibit !== o_busy) inhibit_mism++;
    if (o_ps2c_low === 1'b1) begin
      if (inh_run == 0) inh_starts++;
      inh_run++;
    end else if (inh_run != 0) begin
      last_inh_len = inh_run;
      inh_run = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame as seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Device model: waits for inhibit + request, clocks the frame, samples on rising edges,
  // optionally ACKs on the 11th clock. Stops clocking after stop_after falls when < 10.
  task automatic bfm_frame(input bit ack, input int stop_after,
                           output logic [10:0] got, output int inh_len);
    int n;
    got = '0;
    n = 0;
    while (o_ps2c_low !== 1'b1 && n < TO + INH + 200) begin @(negedge clk); n++; end
    check("inhibit_seen", 32'(o_ps2c_low), 32'd1);
    n = 0;
    while (o_ps2c_low === 1'b1 && n < INH + 200) begin @(negedge clk); n++; end
    check("inhibit_released", 32'(o_ps2c_low), 32'd0);
    @(negedge clk);
    inh_len = last_inh_len;
    got[0] = ps2d;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (k > stop_after) return;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      got[k] = ps2d;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = ack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic [7:0] d, input logic [3:0] ack_mask,
                        input int stop_after, input bit poke);
    logic [10:0] got, mask, expf;
    int inh_len, d0, e0, s0, n, attempts;
    bit success;
    d0 = done_cnt; e0 = err_cnt; s0 = inh_starts;
    @(negedge clk);
    i_data = d; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, ":busy"}, 32'(o_busy), 32'd1);
    if (poke) begin
      i_data = ~d; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    expf = exp_frame(d);
    mask = '0;
    for (int b = 0; b < 11; b++) if (b <= stop_after) mask[b] = 1'b1;
    success = 1'b0;
    attempts = 0;
    for (int a = 0; a < MAX_ATT && !success; a++) begin
      bfm_frame(ack_mask[a], stop_after, got, inh_len);
      attempts++;
      check({tag, ":frame"}, 32'(got & mask), 32'(expf & mask));
      check({tag, ":inhibit_len"}, inh_len, INH);
      success = ack_mask[a] && (stop_after >= 10);
    end
    n = 0;
    while (o_busy === 1'b1 && n < TO + 500) begin @(negedge clk); n++; end
    check({tag, ":idle"}, 32'(o_busy), 32'd0);
    if (stop_after < 10)
      check({tag, ":timeout_window"},
            32'((n >= TO - 2*HALF - 20) && (n <= TO - 2*HALF + 20)), 32'd1);
    if (!success) exp_code = (stop_after < 10) ? 2'b10 : 2'b01;
    repeat (10) @(negedge clk);
    check({tag, ":done_pulses"}, done_cnt - d0, success ? 1 : 0);
    check({tag, ":error_pulses"}, err_cnt - e0, success ? 0 : 1);
    check({tag, ":err_code"}, 32'(o_err_code), 32'(exp_code));
    check({tag, ":clk_released"}, 32'(o_ps2c_low), 32'd0);
    check({tag, ":dat_released"}, 32'(o_ps2d_low), 32'd0);
    check({tag, ":frames"}, inh_starts - s0, attempts);
  endtask

  initial begin
    logic [10:0] got;
    int inh_len;
    reset = 1'b1; i_start = 1'b0; i_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    exp_code = 2'b00;
    repeat (3) @(negedge clk);
    check("rst:ps2c_low", 32'(o_ps2c_low), 32'd0);
    check("rst:ps2d_low", 32'(o_ps2d_low), 32'd0);
    check("rst:busy", 32'(o_busy), 32'd0);
    check("rst:done", 32'(o_done), 32'd0);
    check("rst:error", 32'(o_error), 32'd0);
    check("rst:err_code", 32'(o_err_code), 32'd0);
    check("rst:rx_inhibit", 32'(o_rx_inhibit), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    do_txn("ed", 8'hED, 4'hF, 10, 1'b0);
    do_txn("x00", 8'h00, 4'hF, 10, 1'b0);
    do_txn("xff", 8'hFF, 4'hF, 10, 1'b0);
    do_txn("busy_poke", 8'h3C, 4'hF, 10, 1'b1);
    for (int i = 0; i < 6; i++) do_txn("rand", 8'($urandom_range(255)), 4'hF, 10, 1'b0);
    do_txn("noack", 8'h5A, 4'h0, 10, 1'b0);
    do_txn("timeout", 8'hC3, 4'hF, 4, 1'b0);

    // Reset in the middle of SHIFT: device stops after fall 3, host is driving data[2]=0.
    @(negedge clk);
    i_data = 8'h00; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    bfm_frame(1'b1, 3, got, inh_len);
    check("mid:busy", 32'(o_busy), 32'd1);
    check("mid:ps2d_low", 32'(o_ps2d_low), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst:ps2c_low", 32'(o_ps2c_low), 32'd0);
    check("midrst:ps2d_low", 32'(o_ps2d_low), 32'd0);
    check("midrst:busy", 32'(o_busy), 32'd0);
    check("midrst:rx_inhibit", 32'(o_rx_inhibit), 32'd0);
    check("midrst:err_code", 32'(o_err_code), 32'd0);
    exp_code = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    do_txn("after_rst", 8'h81, 4'hF, 10, 1'b0);
`ifdef PS2_TX_RETRY_EN
    do_txn("retry", 8'h96, 4'b0010, 10, 1'b0);
`endif

    check("rx_inhibit_tracks_busy", inhibit_mism, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
